// File: rtl/alu_sel_pkg.sv
// Shared types and constants for the ALU lane-select expander and decoder.
//   op_e      : ALU operation class carried alongside a select vector
//   p_e       : expander group-size selector
//   sel_vec_t : packed 8-lane x 3-bit lane select vector (lane k = vec[k])
//   result_t  : decoded payload presented on the decoder output
package alu_sel_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned LANE_W    = 3;
  localparam int unsigned NUM_B     = 4;
  localparam int unsigned NUM_H     = 2;

  typedef enum logic [6:0] {
    ALU_N   = 7'd0,
    ALU_B   = 7'd1,
    ALU_H   = 7'd2,
    ALU_BFP = 7'd3
  } op_e;

  typedef enum logic [1:0] {
    P_N = 2'd0,
    P_B = 2'd1,
    P_H = 2'd2
  } p_e;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] sel_vec_t;
  typedef logic [NUM_B-1:0][1:0]            sel_b_t;
  typedef logic [NUM_H-1:0][0:0]            sel_h_t;

  typedef struct packed {
    op_e      op;
    sel_b_t   sel_b;
    sel_h_t   sel_h;
    sel_vec_t sel_n;
  } result_t;

endpackage

// File: rtl/alu_sel_classify.sv
// Combinational classifier: maps a lane select vector to ALU_H / ALU_B / ALU_N
// and recovers the compressed per-group selects.
//   sel   : lane select vector
//   op    : decoded class (H beats B beats N)
//   sel_b : per byte-pair select, zero for ALU_N
//   sel_h : per half select, zero unless ALU_H
module alu_sel_classify
  import alu_sel_pkg::*;
(
  input  logic [NUM_LANES-1:0][LANE_W-1:0] sel,
  output op_e                              op,
  output logic [NUM_B-1:0][1:0]            sel_b,
  output logic [NUM_H-1:0][0:0]            sel_h
);

  localparam int unsigned LANES_PER_H = NUM_LANES / NUM_H;

  logic [NUM_LANES-1:0] h_lane_ok;
  logic [NUM_LANES-1:0] b_lane_ok;
  logic [NUM_B-1:0]     b_pair_ok;
  logic                 h_match;
  logic                 b_match;

  // Per-lane checks: H needs lane index in [1:0] and a common bit 2 per half;
  // B needs lane parity in bit 0.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam int unsigned HBASE = (k / LANES_PER_H) * LANES_PER_H;
    assign h_lane_ok[k] = (sel[k][1:0] == 2'(k)) && (sel[k][2] == sel[HBASE][2]);
    assign b_lane_ok[k] = (sel[k][0] == 1'(k));
  end

  // Both lanes of a byte pair must agree on bits [2:1].
  for (genvar b = 0; b < NUM_B; b++) begin : g_pair
    assign b_pair_ok[b] = (sel[2*b][2:1] == sel[2*b+1][2:1]);
    assign sel_b[b]     = (op != ALU_N) ? sel[2*b][2:1] : 2'b00;
  end

  for (genvar h = 0; h < NUM_H; h++) begin : g_half
    assign sel_h[h] = (op == ALU_H) ? sel[h*LANES_PER_H][2] : 1'b0;
  end

  assign h_match = &h_lane_ok;
  assign b_match = (&b_lane_ok) && (&b_pair_ok);

  // Every H pattern is also a B pattern, so H is tested first.
  always_comb begin
    op = ALU_N;
    if (h_match) begin
      op = ALU_H;
    end else if (b_match) begin
      op = ALU_B;
    end
  end

endmodule

// File: rtl/alu_sel_decoder.sv
// Two-stage valid/ready decoder for ALU lane select vectors, with saturating
// per-class delivery counters.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   in_valid_i/in_ready_o    : input handshake (ready is combinational)
//   in_sel_i                 : lane select vector
//   out_valid_o/out_ready_i  : output handshake
//   out_op_o, out_sel_b_o,
//   out_sel_h_o, out_sel_n_o : decoded class, recovered fields, passthrough
//   cnt_n_o/cnt_b_o/cnt_h_o  : delivered-result counters per class
//   cnt_clr_i                : synchronous counter clear
module alu_sel_decoder
  import alu_sel_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] in_sel_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output op_e                              out_op_o,
  output logic [NUM_B-1:0][1:0]            out_sel_b_o,
  output logic [NUM_H-1:0][0:0]            out_sel_h_o,
  output logic [NUM_LANES-1:0][LANE_W-1:0] out_sel_n_o,
  output logic [CNT_W-1:0]                 cnt_n_o,
  output logic [CNT_W-1:0]                 cnt_b_o,
  output logic [CNT_W-1:0]                 cnt_h_o,
  input  logic                             cnt_clr_i
);

  logic     s1_valid;
  sel_vec_t s1_sel;
  logic     s2_valid;
  result_t  s2_res;
  result_t  cls_res;
  logic     s1_adv;
  logic     s2_adv;
  logic     out_hs;

  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv;
  assign out_hs     = s2_valid && out_ready_i;

  alu_sel_classify u_classify (
    .sel   (s1_sel),
    .op    (cls_res.op),
    .sel_b (cls_res.sel_b),
    .sel_h (cls_res.sel_h)
  );
  assign cls_res.sel_n = s1_sel;

  // Stage 1: capture the raw vector.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_sel <= in_sel_i;
      end
    end
  end

  // Stage 2: capture classification and recovered fields.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= cls_res;
      end
    end
  end

  assign out_valid_o = s2_valid;
  assign out_op_o    = s2_res.op;
  assign out_sel_b_o = s2_res.sel_b;
  assign out_sel_h_o = s2_res.sel_h;
  assign out_sel_n_o = s2_res.sel_n;

  // Saturating per-class counters; clear wins over a same-edge increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || cnt_clr_i) begin
      cnt_n_o <= '0;
      cnt_b_o <= '0;
      cnt_h_o <= '0;
    end else if (out_hs) begin
      case (s2_res.op)
        ALU_N: if (cnt_n_o != {CNT_W{1'b1}}) cnt_n_o <= cnt_n_o + CNT_W'(1);
        ALU_B: if (cnt_b_o != {CNT_W{1'b1}}) cnt_b_o <= cnt_b_o + CNT_W'(1);
        ALU_H: if (cnt_h_o != {CNT_W{1'b1}}) cnt_h_o <= cnt_h_o + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sel_decoder.sv
// Directed self-checking bench for alu_sel_decoder (CNT_W = 4).
module tb_alu_sel_decoder;
  import alu_sel_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_ni;
  logic             in_valid_i;
  logic             in_ready_o;
  sel_vec_t         in_sel_i;
  logic             out_valid_o;
  logic             out_ready_i;
  op_e              out_op_o;
  sel_b_t           out_sel_b_o;
  sel_h_t           out_sel_h_o;
  sel_vec_t         out_sel_n_o;
  logic [CNT_W-1:0] cnt_n_o;
  logic [CNT_W-1:0] cnt_b_o;
  logic [CNT_W-1:0] cnt_h_o;
  logic             cnt_clr_i;

  int n_cmp;
  int n_err;

  alu_sel_decoder #(.CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_sel_i    (in_sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_op_o    (out_op_o),
    .out_sel_b_o (out_sel_b_o),
    .out_sel_h_o (out_sel_h_o),
    .out_sel_n_o (out_sel_n_o),
    .cnt_n_o     (cnt_n_o),
    .cnt_b_o     (cnt_b_o),
    .cnt_h_o     (cnt_h_o),
    .cnt_clr_i   (cnt_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sel_vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6, input int a7);
    sel_vec_t v;
    v[0] = 3'(a0); v[1] = 3'(a1); v[2] = 3'(a2); v[3] = 3'(a3);
    v[4] = 3'(a4); v[5] = 3'(a5); v[6] = 3'(a6); v[7] = 3'(a7);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_sel_i    = '0;
    out_ready_i = 1'b1;
    cnt_clr_i   = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    n_cmp++; if (out_op_o !== ALU_N) begin n_err++; $display("FAIL reset_op got=%0d exp=0", out_op_o); end
    n_cmp++; if ({cnt_n_o, cnt_b_o, cnt_h_o} !== 12'h000) begin n_err++; $display("FAIL reset_cnt got=%h exp=000", {cnt_n_o, cnt_b_o, cnt_h_o}); end
  endtask

  task automatic test_identity();
    in_valid_i = 1'b1; in_sel_i = mk(0, 1, 2, 3, 4, 5, 6, 7); out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL id_valid got=%b exp=1", out_valid_o); end
    n_cmp++; if (out_op_o !== ALU_H) begin n_err++; $display("FAIL id_op got=%0d exp=2", out_op_o); end
    n_cmp++; if (out_sel_h_o !== 2'b10) begin n_err++; $display("FAIL id_sel_h got=%b exp=10", out_sel_h_o); end
    n_cmp++; if (out_sel_b_o !== 8'b11_10_01_00) begin n_err++; $display("FAIL id_sel_b got=%b exp=11100100", out_sel_b_o); end
    tick();
    n_cmp++; if (cnt_h_o !== 4'd1) begin n_err++; $display("FAIL id_cnt_h got=%0d exp=1", cnt_h_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL id_drain got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_b_pattern();
    in_valid_i = 1'b1; in_sel_i = mk(0, 1, 0, 1, 0, 1, 0, 1);
    tick();
    in_valid_i = 1'b0;
    tick();
    n_cmp++; if (out_op_o !== ALU_B) begin n_err++; $display("FAIL b_op got=%0d exp=1", out_op_o); end
    n_cmp++; if (out_sel_b_o !== 8'h00) begin n_err++; $display("FAIL b_sel_b got=%b exp=00000000", out_sel_b_o); end
    n_cmp++; if (out_sel_h_o !== 2'b00) begin n_err++; $display("FAIL b_sel_h got=%b exp=00", out_sel_h_o); end
    tick();
    n_cmp++; if (cnt_b_o !== 4'd1) begin n_err++; $display("FAIL b_cnt_b got=%0d exp=1", cnt_b_o); end
  endtask

  task automatic test_n_pattern();
    sel_vec_t v;
    v = mk(7, 1, 2, 3, 4, 5, 6, 7);
    in_valid_i = 1'b1; in_sel_i = v;
    tick();
    in_valid_i = 1'b0;
    tick();
    n_cmp++; if (out_op_o !== ALU_N) begin n_err++; $display("FAIL n_op got=%0d exp=0", out_op_o); end
    n_cmp++; if (out_sel_b_o !== 8'h00 || out_sel_h_o !== 2'b00) begin n_err++; $display("FAIL n_fields got=%b/%b exp=0/0", out_sel_b_o, out_sel_h_o); end
    n_cmp++; if (out_sel_n_o !== v) begin n_err++; $display("FAIL n_pass got=%h exp=%h", out_sel_n_o, v); end
    tick();
    n_cmp++; if (cnt_n_o !== 4'd1) begin n_err++; $display("FAIL n_cnt_n got=%0d exp=1", cnt_n_o); end
  endtask

  task automatic test_back_to_back();
    sel_vec_t vecs [4];
    op_e      ops  [4];
    sel_b_t   sbs  [4];
    int       tx, rx;
    logic     saw_stall, accept, held_v;
    op_e      held_op;
    sel_vec_t held_n;
    vecs[0] = mk(0, 1, 2, 3, 4, 5, 6, 7); ops[0] = ALU_H; sbs[0] = 8'b11_10_01_00;
    vecs[1] = mk(0, 1, 0, 1, 0, 1, 0, 1); ops[1] = ALU_B; sbs[1] = 8'b00_00_00_00;
    vecs[2] = mk(7, 1, 2, 3, 4, 5, 6, 7); ops[2] = ALU_N; sbs[2] = 8'b00_00_00_00;
    vecs[3] = mk(2, 3, 2, 3, 6, 7, 4, 5); ops[3] = ALU_B; sbs[3] = 8'b10_11_01_01;
    do_reset();
    tx = 0; rx = 0; saw_stall = 1'b0; held_v = 1'b0; held_op = ALU_N; held_n = '0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      out_ready_i = !(c >= 3 && c <= 5);
      in_valid_i  = (tx < 4);
      in_sel_i    = (tx < 4) ? vecs[tx] : '0;
      #1;
      if (in_valid_i && !in_ready_o) saw_stall = 1'b1;
      if (held_v) begin
        n_cmp++;
        if (out_valid_o !== 1'b1 || out_op_o !== held_op || out_sel_n_o !== held_n) begin
          n_err++; $display("FAIL b2b_stable cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_valid_o, out_op_o, out_sel_n_o, held_op, held_n);
        end
      end
      if (out_valid_o && out_ready_i) begin
        n_cmp++;
        if (out_op_o !== ops[rx] || out_sel_n_o !== vecs[rx] || out_sel_b_o !== sbs[rx]) begin
          n_err++; $display("FAIL b2b_order idx=%0d got=%0d/%h/%b exp=%0d/%h/%b", rx, out_op_o, out_sel_n_o, out_sel_b_o, ops[rx], vecs[rx], sbs[rx]);
        end
        rx++;
      end
      held_v  = out_valid_o && !out_ready_i;
      held_op = out_op_o;
      held_n  = out_sel_n_o;
      accept  = in_valid_i && in_ready_o;
      @(posedge clk);
      if (accept) tx++;
      #1;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    n_cmp++; if (rx !== 4) begin n_err++; $display("FAIL b2b_delivered got=%0d exp=4", rx); end
    n_cmp++; if (saw_stall !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready_drop got=%b exp=1", saw_stall); end
    n_cmp++; if ({cnt_h_o, cnt_b_o, cnt_n_o} !== {4'd1, 4'd2, 4'd1}) begin n_err++; $display("FAIL b2b_cnt got=h%0d b%0d n%0d exp=h1 b2 n1", cnt_h_o, cnt_b_o, cnt_n_o); end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    in_sel_i = mk(0, 1, 0, 1, 0, 1, 0, 1);
    in_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    in_valid_i = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (cnt_b_o !== 4'd15) begin n_err++; $display("FAIL sat_cnt_b got=%0d exp=15", cnt_b_o); end
    n_cmp++; if (cnt_h_o !== 4'd0 || cnt_n_o !== 4'd0) begin n_err++; $display("FAIL sat_others got=h%0d n%0d exp=0", cnt_h_o, cnt_n_o); end
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL clr_setup got=%b exp=1", out_valid_o); end
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    n_cmp++; if (cnt_b_o !== 4'd0) begin n_err++; $display("FAIL clr_cnt_b got=%0d exp=0", cnt_b_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_sel_i = mk(0, 1, 2, 3, 4, 5, 6, 7);
    tick();
    in_sel_i = mk(0, 1, 0, 1, 0, 1, 0, 1);
    tick();
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", out_valid_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_ready got=%b exp=1", in_ready_o); end
    n_cmp++; if (out_op_o !== ALU_N) begin n_err++; $display("FAIL rmid_op got=%0d exp=0", out_op_o); end
    n_cmp++; if ({cnt_n_o, cnt_b_o, cnt_h_o} !== 12'h000) begin n_err++; $display("FAIL rmid_cnt got=%h exp=000", {cnt_n_o, cnt_b_o, cnt_h_o}); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_flushed got=%b exp=0", out_valid_o); end
    in_valid_i = 1'b1; in_sel_i = mk(0, 1, 2, 3, 4, 5, 6, 7);
    tick();
    in_valid_i = 1'b0;
    tick();
    n_cmp++; if (out_valid_o !== 1'b1 || out_op_o !== ALU_H) begin n_err++; $display("FAIL rmid_next got=%b/%0d exp=1/2", out_valid_o, out_op_o); end
    tick();
    n_cmp++; if (cnt_h_o !== 4'd1) begin n_err++; $display("FAIL rmid_cnt_h got=%0d exp=1", cnt_h_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_ni = 1'b0; in_valid_i = 1'b0; in_sel_i = '0; out_ready_i = 1'b1; cnt_clr_i = 1'b0;
    test_reset();
    test_identity();
    test_b_pattern();
    test_n_pattern();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
